// File: rtl/game_ctrl.sv
// Round sequencer for Watch Your Step: IDLE/RUN/HIT/PAUSED/OVER flow driving the lives counter.
// Build option GAME_AUTO_RESUME_EN drops PAUSED and resumes play straight out of HIT.
module game_ctrl #(
  parameter int FLASH_FRAMES = 120,
  parameter int FLASH_SHIFT  = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_i,
  input  logic       btnC_i,
  input  logic       btnL_i,
  input  logic [7:0] sw_i,
  input  logic       hit_i,
  input  logic [7:0] lives_i,
  output logic [7:0] din_o,
  output logic       ld_o,
  output logic       dw_o,
  output logic       run_o,
  output logic       flash_o,
  output logic       restart_o,
  output logic       game_over_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_HIT    = 3'd2,
    S_OVER   = 3'd3
`ifndef GAME_AUTO_RESUME_EN
    , S_PAUSED = 3'd4
`endif
  } state_e;

  localparam logic [7:0] FLASH_INIT = 8'(FLASH_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       btnc_prev_q, btnl_prev_q;
  logic       ld_q, ld_d;
  logic       dw_q, dw_d;
  logic       run_q, run_d;
  logic       flash_q, flash_d;
  logic       restart_q, restart_d;
  logic       over_q, over_d;
  logic       btnc_rise, btnl_rise, lives_zero;

  assign btnc_rise  = btnC_i & ~btnc_prev_q;
  assign btnl_rise  = btnL_i & ~btnl_prev_q;
  assign lives_zero = (lives_i == 8'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_d      = 1'b0;
    dw_d      = 1'b0;
    restart_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A load takes priority and swallows a simultaneous start press.
        if (btnl_rise) begin
          ld_d = 1'b1;
        end else if (btnc_rise && !lives_zero) begin
          restart_d = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (frame_i && hit_i) begin
          if (lives_zero) begin
            state_d = S_OVER;
          end else begin
            dw_d    = 1'b1;
            cnt_d   = FLASH_INIT;
            state_d = S_HIT;
          end
        end
      end
      S_HIT: begin
        if (frame_i) begin
          if (cnt_q == 8'd1) begin
            cnt_d = 8'd0;
            if (lives_zero) begin
              state_d = S_OVER;
            end else begin
`ifdef GAME_AUTO_RESUME_EN
              restart_d = 1'b1;
              state_d   = S_RUN;
`else
              state_d   = S_PAUSED;
`endif
            end
          end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
`ifndef GAME_AUTO_RESUME_EN
      S_PAUSED: begin
        if (btnc_rise) begin
          restart_d = 1'b1;
          state_d   = S_RUN;
        end
      end
`endif
      S_OVER: begin
        if (btnc_rise) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // Level outputs follow the next state so they line up with the pulses.
    run_d   = (state_d == S_RUN);
    over_d  = (state_d == S_OVER);
    flash_d = (state_d == S_HIT) & cnt_d[FLASH_SHIFT];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      btnc_prev_q <= 1'b1;
      btnl_prev_q <= 1'b1;
      ld_q        <= 1'b0;
      dw_q        <= 1'b0;
      run_q       <= 1'b0;
      flash_q     <= 1'b0;
      restart_q   <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btnc_prev_q <= btnC_i;
      btnl_prev_q <= btnL_i;
      ld_q        <= ld_d;
      dw_q        <= dw_d;
      run_q       <= run_d;
      flash_q     <= flash_d;
      restart_q   <= restart_d;
      over_q      <= over_d;
    end
  end

  assign din_o       = sw_i;
  assign ld_o        = ld_q;
  assign dw_o        = dw_q;
  assign run_o       = run_q;
  assign flash_o     = flash_q;
  assign restart_o   = restart_q;
  assign game_over_o = over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: vector table for load/start/collision, hand sequences for HIT timing and resets.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_i, frame_i, btnC_i, btnL_i, hit_i;
  logic [7:0] sw_i, lives_i;
  logic [7:0] din_o;
  logic       ld_o, dw_o, run_o, flash_o, restart_o, game_over_o;
  logic [5:0] outs;

  int n_checks = 0;
  int n_pass   = 0;

  game_ctrl #(.FLASH_FRAMES(120), .FLASH_SHIFT(3)) dut (
    .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .btnC_i(btnC_i), .btnL_i(btnL_i),
    .sw_i(sw_i), .hit_i(hit_i), .lives_i(lives_i), .din_o(din_o), .ld_o(ld_o), .dw_o(dw_o),
    .run_o(run_o), .flash_o(flash_o), .restart_o(restart_o), .game_over_o(game_over_o)
  );

  always #5 clk = ~clk;

  // Output bundle order: {ld, dw, run, flash, restart, game_over}
  assign outs = {ld_o, dw_o, run_o, flash_o, restart_o, game_over_o};

  typedef struct {
    logic       btnc;
    logic       btnl;
    logic       frame;
    logic       hit;
    logic [7:0] lives;
    logic [5:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  // Steps n frames (1..119) inside HIT with hit held high; flash follows bit 3 of (120-k).
  task automatic hit_frames(input string tag, input int n);
    logic [7:0] c;
    logic [5:0] e;
    for (int k = 1; k <= n; k++) begin
      hit_i   = 1'b1;
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      c = 8'(120 - k);
      e = {3'b000, c[3], 2'b00};
      chk($sformatf("%s_frame%0d", tag, k), {2'b00, outs}, {2'b00, e});
      btnC_i = (k == 60);
      tick();
    end
    hit_i  = 1'b0;
    btnC_i = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b000000};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 6'b100000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 6'b000000};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 6'b000000};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 6'b001010};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 6'b001000};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 6'b001000};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 6'b001000};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 6'b010100};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 6'b000100};

    reset_i = 1'b1; frame_i = 1'b0; btnC_i = 1'b0; btnL_i = 1'b0; hit_i = 1'b0;
    sw_i = 8'd3; lives_i = 8'd0;
    tick();
    tick();
    chk("reset_outs", {2'b00, outs}, 8'h00);
    chk("din_pass_3", din_o, 8'd3);
    sw_i = 8'h5A;
    #1;
    chk("din_pass_5a", din_o, 8'h5A);
    sw_i = 8'd3;
    reset_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      btnC_i  = vecs[i].btnc;
      btnL_i  = vecs[i].btnl;
      frame_i = vecs[i].frame;
      hit_i   = vecs[i].hit;
      lives_i = vecs[i].lives;
      tick();
      chk($sformatf("vec%0d", i), {2'b00, outs}, {2'b00, vecs[i].exp});
    end
    frame_i = 1'b0; hit_i = 1'b0; btnC_i = 1'b0; btnL_i = 1'b0;

    // Collision with lives left: 120 frames of HIT, then resume.
    hit_frames("hit1", 119);
    frame_i = 1'b1;
    tick();
    frame_i = 1'b0;
`ifdef GAME_AUTO_RESUME_EN
    chk("hit1_exit", {2'b00, outs}, 8'b00001010);
    tick();
    chk("hit1_run", {2'b00, outs}, 8'b00001000);
`else
    chk("hit1_exit_paused", {2'b00, outs}, 8'h00);
    tick();
    chk("paused_hold", {2'b00, outs}, 8'h00);
    btnC_i = 1'b1;
    tick();
    chk("paused_resume", {2'b00, outs}, 8'b00001010);
    btnC_i = 1'b0;
    tick();
    chk("paused_run", {2'b00, outs}, 8'b00001000);
`endif

    // Last life: collision, counter hits zero, game over.
    lives_i = 8'd1; frame_i = 1'b1; hit_i = 1'b1;
    tick();
    chk("last_dw", {2'b00, outs}, 8'b00010100);
    frame_i = 1'b0; hit_i = 1'b0; lives_i = 8'd0;
    tick();
    chk("last_dw_once", {2'b00, outs}, 8'b00000100);
    hit_frames("hit2", 119);
    frame_i = 1'b1;
    tick();
    frame_i = 1'b0;
    chk("game_over", {2'b00, outs}, 8'b00000001);
    btnC_i = 1'b1;
    tick();
    chk("over_to_idle", {2'b00, outs}, 8'h00);
    btnC_i = 1'b0;
    tick();
    btnC_i = 1'b1;
    tick();
    chk("idle_no_lives_start", {2'b00, outs}, 8'h00);
    btnC_i = 1'b0;
    tick();

    // Both buttons rising together in IDLE: load only.
    lives_i = 8'd3; btnL_i = 1'b1; btnC_i = 1'b1;
    tick();
    chk("both_btn_ld_only", {2'b00, outs}, 8'b00100000);
    btnL_i = 1'b0; btnC_i = 1'b0;
    tick();
    chk("both_btn_stay_idle", {2'b00, outs}, 8'h00);
    btnC_i = 1'b1;
    tick();
    chk("idle_start_again", {2'b00, outs}, 8'b00001010);
    btnC_i = 1'b0;

    // Collision in RUN with a corrupted zero count goes straight to OVER, no decrement.
    lives_i = 8'd0; frame_i = 1'b1; hit_i = 1'b1;
    tick();
    chk("run_zero_lives_over", {2'b00, outs}, 8'b00000001);
    frame_i = 1'b0; hit_i = 1'b0;
    btnC_i = 1'b1;
    tick();
    chk("over_exit2", {2'b00, outs}, 8'h00);
    btnC_i = 1'b0;
    tick();

    // Buttons held through reset release produce no edge.
    lives_i = 8'd3; btnC_i = 1'b1; btnL_i = 1'b1; reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
    chk("held_reset_1", {2'b00, outs}, 8'h00);
    tick();
    chk("held_reset_2", {2'b00, outs}, 8'h00);
    btnC_i = 1'b0; btnL_i = 1'b0;
    tick();

    // Reset during HIT aborts the round.
    btnC_i = 1'b1;
    tick();
    chk("mid_start", {2'b00, outs}, 8'b00001010);
    btnC_i = 1'b0; frame_i = 1'b1; hit_i = 1'b1;
    tick();
    chk("mid_hit", {2'b00, outs}, 8'b00010100);
    frame_i = 1'b0; hit_i = 1'b0; lives_i = 8'd2; reset_i = 1'b1;
    tick();
    chk("mid_reset", {2'b00, outs}, 8'h00);
    reset_i = 1'b0;
    tick();
    chk("mid_after_reset", {2'b00, outs}, 8'h00);
    frame_i = 1'b1;
    tick();
    chk("mid_frame_idle", {2'b00, outs}, 8'h00);
    frame_i = 1'b0;
    tick();
    chk("mid_idle_hold", {2'b00, outs}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-flow sequencer for the Watch Your Step game. It owns the run/hit/pause/over state of a round and drives the control inputs of the lives counter: load, decrement and the restart strobe. It also gates object motion and player flashing for the display and scoring logic. It sits between the debounced buttons, the frame-tick generator and collision detector on one side, and the lives counter and VGA object logic on the other.

## Interface
- FLASH_FRAMES, 120, frames spent in HIT after a collision (2 s at 60 Hz); 1..255
- FLASH_SHIFT, 3, flash_o toggles every 2^FLASH_SHIFT frames during HIT
- clk_i  in  1  system clock; all logic is single-clock
- reset_i  in  1  synchronous, active-high reset
- frame_i  in  1  one-cycle pulse per video frame (refresh)
- btnC_i  in  1  debounced centre button, level
- btnL_i  in  1  debounced left button, level
- sw_i  in  8  starting lives, forwarded to the counter's load data
- hit_i  in  1  player/obstacle collision, level; sampled only when frame_i=1
- lives_i  in  8  current lives count, fed back from the counter Q
- din_o  out  8  load data for the counter; equals sw_i, combinational passthrough
- ld_o  out  1  one-cycle pulse: counter loads din_o
- dw_o  out  1  one-cycle pulse: counter decrements by one
- run_o  out  1  high while objects move (state RUN)
- flash_o  out  1  player blink enable during HIT
- restart_o  out  1  one-cycle pulse: object positions return to start
- game_over_o  out  1  high in state OVER

## Operation
- Rising-edge detect on btnC_i and btnL_i. The edge history registers are set to 1 by reset, so a button held through reset produces no edge.
- States and transitions:
  - IDLE
    - btnL rise: ld_o pulse.
    - btnC rise with lives_i≠0: restart_o pulse, go to RUN.
    - btnC rise with lives_i=0: ignored.
    - btnL and btnC rising in the same cycle: load only; btnC is dropped.
  - RUN
    - run_o=1.
    - frame_i&hit_i: dw_o pulse, flash counter loaded with FLASH_FRAMES, go to HIT.
    - Buttons ignored.
  - HIT
    - run_o=0.
    - Flash counter decrements on each frame_i.
    - flash_o = bit FLASH_SHIFT of the counter.
    - When the counter is 1 and frame_i=1: go to OVER if lives_i=0, else go to PAUSED. Counter becomes 0.
    - hit_i and buttons ignored.
  - PAUSED
    - btnC rise: restart_o pulse, go to RUN.
  - OVER
    - game_over_o=1.
    - btnC rise: go to IDLE. No load is issued; the player must press btnL to reload lives.
- dw_o is never asserted when lives_i=0. A collision in RUN with lives_i=0 (counter externally corrupted) goes straight to OVER.
- ld_o is asserted only in IDLE.
- Width rule: lives_i is compared as unsigned 8-bit against zero only. The flash counter is 8-bit.

## Timing
- Reset values: state IDLE, flash counter 0. All outputs are 0 except din_o, which follows sw_i.
- All outputs except din_o are registered. A pulse or state change appears on the cycle after the input sample that triggers it.
- ld_o, dw_o and restart_o are exactly one cycle wide.
- dw_o is asserted in the first HIT cycle. lives_i reflects the decrement one cycle later; the HIT exit check happens no earlier than FLASH_FRAMES frames after that, so it always sees the updated value.
- Reset asserted in any state aborts the round within one cycle: IDLE, outputs cleared, no pending pulse.

## Configuration
- GAME_AUTO_RESUME_EN
  - Undefined: HIT exits to PAUSED when lives remain.
  - Defined: the PAUSED state is removed. HIT with lives_i≠0 issues a restart_o pulse and returns directly to RUN on the same cycle it would have entered PAUSED.

## Test plan
- Load and start:
  - reset, sw_i=3, btnL press → single ld_o pulse.
  - With lives_i=3, btnC press → single restart_o pulse, run_o=1 the next cycle.
- Collision:
  - In RUN, hit_i=1 with frame_i → one dw_o pulse, run_o=0.
  - flash_o toggles every 8 frames.
  - After 120 frames → PAUSED (run_o=0, flash_o=0).
  - btnC press → restart_o, RUN.
- Last life:
  - lives_i=1, collision → dw_o, lives_i=0.
  - After 120 frames → game_over_o=1.
  - btnC press → IDLE.
  - btnC again with lives_i=0 → no restart_o.
- Simultaneous buttons and held reset:
  - btnL and btnC rising in the same IDLE cycle → ld_o only, state stays IDLE.
  - Button held through reset release → no pulse.
- Mid-round reset: reset_i for 1 cycle during HIT → next cycle IDLE, all outputs 0, no dw_o/restart_o emitted.
- GAME_AUTO_RESUME_EN defined: collision with lives_i=2 → after 120 frames restart_o pulse and run_o=1 with no button press.
